// File: rtl/sram_master.sv
// CPU-side controller for a single-port 256x32 SRAM: byte/halfword/word loads and stores,
// with sub-word stores done as read-modify-write and misaligned requests rejected.
module sram_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        CSram,
  output logic        EscrMem,
  output logic        LeerMem,
  output logic [7:0]  Direc,
  output logic [31:0] Datain,
  input  logic [31:0] Dataout
);

  typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StDone} state_e;

  state_e      state_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] datain_q;
  logic [7:0]  direc_q;

  logic        illegal;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    illegal = (size == 2'b11) ||
              ((size == 2'b01) && addr[0]) ||
              ((size == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Lane extraction and merge both work on the word the SRAM holds on Dataout during RDW.
  always_comb begin
    lane_byte = Dataout[{lane_q, 3'b000} +: 8];
    lane_half = Dataout[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{~uns_q & lane_half[15]}}, lane_half};
      default: load_val = Dataout;
    endcase
    merged = Dataout;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      datain_q <= '0;
      direc_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= uns;
            lane_q  <= addr[1:0];
            wdata_q <= wdata[15:0];
            direc_q <= addr[9:2];
            err_q   <= illegal;
            if (illegal) begin
              state_q <= StDone;
            end else if (we && (size == 2'b10)) begin
              datain_q <= wdata;
              state_q  <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd:  state_q <= StRdw;
        StRdw: begin
          if (we_q) begin
            datain_q <= merged;
            state_q  <= StWr;
          end else begin
            rdata_q <= load_val;
            state_q <= StDone;
          end
        end
        StWr:  state_q <= StDone;
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes are pure state decodes so an asynchronous reset clears them at once.
  assign ready   = (state_q == StIdle);
  assign ack     = (state_q == StDone);
  assign CSram   = (state_q == StRd) || (state_q == StWr);
  assign LeerMem = (state_q == StRd);
  assign EscrMem = (state_q == StWr);
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign Direc   = direc_q;
  assign Datain  = datain_q;

endmodule

// File: tb/tb_sram_master.sv
// Randomized bench for sram_master: a transaction-level model predicts strobes, latency,
// write data and load results; a behavioural SRAM answers the DUT.
module tb_sram_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        CSram;
  logic        EscrMem;
  logic        LeerMem;
  logic [7:0]  Direc;
  logic [31:0] Datain;
  logic [31:0] Dataout;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sram_mem [256];
  logic [31:0] model_mem [256];
  logic        mem_init = 1'b0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  sram_master dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .size    (size),
    .uns     (uns),
    .addr    (addr),
    .wdata   (wdata),
    .ready   (ready),
    .ack     (ack),
    .err     (err),
    .rdata   (rdata),
    .CSram   (CSram),
    .EscrMem (EscrMem),
    .LeerMem (LeerMem),
    .Direc   (Direc),
    .Datain  (Datain),
    .Dataout (Dataout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Behavioural SRAM: read data registered on the edge ending the read cycle, then held.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (CSram && LeerMem) Dataout <= sram_mem[Direc];
      if (CSram && EscrMem) sram_mem[Direc] <= Datain;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_junk();
    req   = 1'($urandom_range(0, 1));
    we    = 1'($urandom_range(0, 1));
    size  = 2'($urandom);
    uns   = 1'($urandom_range(0, 1));
    addr  = 10'($urandom);
    wdata = $urandom;
  endtask

  // Starts at a negedge with the controller idle; ends at the negedge of the following idle cycle.
  task automatic do_txn(input logic t_we, input logic [1:0] t_size, input logic t_uns,
                        input logic [9:0] t_addr, input logic [31:0] t_wdata,
                        output logic [31:0] got_datain, output logic got_err);
    logic        bad;
    int          n, rd_c, wr_c, sh, hs;
    logic [7:0]  idx;
    logic [31:0] old, v, m, d, exp_din;

    check1("ready_idle", ready, 1'b1);
    req = 1'b1; we = t_we; size = t_size; uns = t_uns; addr = t_addr; wdata = t_wdata;

    bad = (t_size == 2'd3) || ((t_size == 2'd1) && t_addr[0]) ||
          ((t_size == 2'd2) && (t_addr[1:0] != 2'd0));
    idx = t_addr[9:2];
    old = model_mem[idx];
    sh  = 8 * int'(t_addr[1:0]);
    hs  = t_addr[1] ? 16 : 0;
    rd_c = 0; wr_c = 0; exp_din = '0; v = '0;
    if (bad) begin
      n = 1;
    end else if (t_we && (t_size == 2'd2)) begin
      n = 2; wr_c = 1; exp_din = t_wdata;
    end else if (!t_we) begin
      n = 3; rd_c = 1;
    end else begin
      n = 4; rd_c = 1; wr_c = 3;
    end

    case (t_size)
      2'd0: begin
        v = (old >> sh) & 32'hFF;
        if (!t_uns && v[7]) v = v | 32'hFFFFFF00;
        m = 32'hFF << sh;
        d = (t_wdata & 32'hFF) << sh;
      end
      2'd1: begin
        v = (old >> hs) & 32'hFFFF;
        if (!t_uns && v[15]) v = v | 32'hFFFF0000;
        m = 32'hFFFF << hs;
        d = (t_wdata & 32'hFFFF) << hs;
      end
      default: begin
        v = old; m = '0; d = '0;
      end
    endcase
    if (!bad && t_we && (t_size != 2'd2)) exp_din = (old & ~m) | d;
    if (!bad && t_we) model_mem[idx] = exp_din;

    got_datain = '0;
    got_err    = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check1("ready_busy", ready, 1'b0);
      check1("csram", CSram, (k == rd_c) || (k == wr_c));
      check1("leermem", LeerMem, k == rd_c);
      check1("escrmem", EscrMem, k == wr_c);
      check1("ack", ack, k == n);
      check1("err", err, (k == n) && bad);
      check32("direc", {24'b0, Direc}, {24'b0, idx});
      if (k == wr_c) begin
        check32("datain", Datain, exp_din);
        got_datain = Datain;
      end
      if (k == n) begin
        if (!bad && !t_we) exp_rdata = v;
        got_err = err;
      end
      check32("rdata", rdata, exp_rdata);
      drive_junk();
    end
    @(negedge clk);
    check1("ready_after", ready, 1'b1);
    check1("ack_after", ack, 1'b0);
    req = 1'b0;
  endtask

  task automatic reset_mid_op();
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 10'h020; wdata = $urandom;
    @(negedge clk);
    check1("rst_rd_cs", CSram, 1'b1);
    check1("rst_rd_le", LeerMem, 1'b1);
    req = 1'b0;
    #1 rst = 1'b1;
    #1;
    check1("rst_cs", CSram, 1'b0);
    check1("rst_we", EscrMem, 1'b0);
    check1("rst_le", LeerMem, 1'b0);
    check1("rst_ack", ack, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("rst_rdata", rdata, 32'h0);
    check32("rst_direc", {24'b0, Direc}, 32'h0);
    check32("rst_datain", Datain, 32'h0);
    exp_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      check1("rst_no_ack", ack, 1'b0);
      check1("rst_no_cs", CSram, 1'b0);
    end
    rst = 1'b0;
  endtask

  initial begin : main
    logic [31:0] din;
    logic        e;
    int          gap;

    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    exp_rdata = '0;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check1("reset_ack", ack, 1'b0);
    check1("reset_cs", CSram, 1'b0);
    check32("reset_rdata", rdata, 32'h0);
    check32("reset_datain", Datain, 32'h0);
    rst = 1'b0;

    do_txn(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, din, e);
    check32("lit_wstore_din", din, 32'hDEADBEEF);
    do_txn(1'b0, 2'd2, 1'b1, 10'h010, 32'h0, din, e);
    check32("lit_wload", rdata, 32'hDEADBEEF);
    do_txn(1'b1, 2'd0, 1'b0, 10'h012, 32'hAAAAAA55, din, e);
    check32("lit_bstore_din", din, 32'hDE55BEEF);
    do_txn(1'b0, 2'd0, 1'b0, 10'h013, 32'h0, din, e);
    check32("lit_bload_s", rdata, 32'hFFFFFFDE);
    do_txn(1'b0, 2'd0, 1'b1, 10'h013, 32'h0, din, e);
    check32("lit_bload_u", rdata, 32'h000000DE);
    do_txn(1'b0, 2'd1, 1'b0, 10'h011, 32'h0, din, e);
    check1("lit_half_err", e, 1'b1);
    do_txn(1'b1, 2'd3, 1'b0, 10'h000, 32'h12345678, din, e);
    check1("lit_size3_err", e, 1'b1);

    reset_mid_op();
    do_txn(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, din, e);
    check32("lit_abort_unchanged", rdata, init_word(8));

    for (int t = 0; t < 400; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      do_txn(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)),
             10'($urandom), $urandom, din, e);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) check32("mem_final", sram_mem[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_master.md
SRAM_MASTER -- requirements
Module: sram_master

Interface
REQ-001 No parameters; widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  1  CPU access request; sampled only while ready=1.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 uns  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-008 addr  in  10  CPU byte address; addr[9:2] = word index, addr[1:0] = byte lane.
REQ-009 wdata  in  32  store data, right-justified.
REQ-010 ready  out  1  controller idle and accepting a request.
REQ-011 ack  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with ack; 1 = request rejected, no SRAM access.
REQ-013 rdata  out  32  load result, valid with ack, held until the next ack.
REQ-014 CSram  out  1  SRAM chip select.
REQ-015 EscrMem  out  1  SRAM write enable.
REQ-016 LeerMem  out  1  SRAM read enable.
REQ-017 Direc  out  8  SRAM word address.
REQ-018 Datain  out  32  SRAM write data.
REQ-019 Dataout  in  32  SRAM read data, registered by the SRAM on the edge ending a read cycle, then held.

Function
REQ-020 FSM states: IDLE, RD, RDW, WR, DONE; ready=1 only in IDLE.
REQ-021 IDLE & req=1 at an edge: latch we/size/uns/addr/wdata; Direc=latched addr[9:2] until the next accept.
REQ-022 Illegal request (size=11, halfword with addr[0]=1, or word with addr[1:0]!=0): IDLE->DONE with err=1; no SRAM access.
REQ-023 Legal word store: IDLE->WR. Load or legal byte/halfword store: IDLE->RD.
REQ-024 RD: CSram=1, LeerMem=1, EscrMem=0, for exactly one cycle; then ->RDW.
REQ-025 RDW, load: register the extracted, extended lane into rdata; ->DONE.
REQ-026 RDW, sub-word store: merge wdata[7:0] or wdata[15:0] into the Dataout word at the addressed lane; other bytes unchanged; ->WR.
REQ-027 Lane mapping is little-endian: byte k = bits [8k+7:8k]; halfword = bits [16*addr[1]+15:16*addr[1]].
REQ-028 WR: CSram=1, EscrMem=1, LeerMem=0, Datain=word or merged word, for exactly one cycle; then ->DONE.
REQ-029 DONE: ack=1 for one cycle; err=1 only for rejected requests; then ->IDLE.
REQ-030 In IDLE, RDW and DONE: CSram=EscrMem=LeerMem=0. These strobes are decoded from state only (Moore).
REQ-031 Latency from the accepting edge to ack high: error 1 cycle, word store 2, load 3, sub-word store 4.
REQ-032 Word load: rdata=Dataout unmodified, regardless of uns.
REQ-033 req is ignored while ready=0; no queuing.
REQ-034 Back-to-back accept: req held high gives a new accept on the edge that enters IDLE+1, i.e. the first edge with ready=1.

Reset
REQ-035 rst=1 forces, immediately and without clk, state=IDLE, CSram=EscrMem=LeerMem=0, ack=err=0, rdata=0, Direc=0, Datain=0.
REQ-036 Reset mid-operation aborts the access with no ack; if rst is high across the WR edge, no SRAM write occurs.
REQ-037 After rst falls, ready=1 and the first accept may occur on the next edge.

Verification
REQ-038 Word store, addr=0x010, wdata=0xDEADBEEF -> one WR cycle with Direc=0x04 and Datain=0xDEADBEEF; ack 2 cycles after accept; err=0.
REQ-039 Word load of that location -> one RD cycle, then ack 3 cycles after accept; rdata=0xDEADBEEF.
REQ-040 Byte store of wdata=0x55 at addr=0x012 -> sequence RD, RDW, WR with Datain=0xDE55BEEF; ack at cycle 4.
REQ-041 Byte load at addr=0x013: uns=0 -> rdata=0xFFFFFFDE; uns=1 -> rdata=0x000000DE.
REQ-042 Halfword access at addr=0x011, or size=11 -> ack and err=1 after 1 cycle; CSram never asserted.
REQ-043 Assert rst during the RD cycle of a sub-word store -> outputs zeroed immediately; no WR occurs and no ack; memory word unchanged.
